// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI incrementing-burst slave on a 1-cycle-latency synchronous SRAM
module axi_sram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           awaddr,
    input  logic [7:0]            awlen,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_we,
    output logic                  sram_re,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  wlast_err
);
    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_BURST} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [8:0]            cnt_q;
    logic                  prefer_write;
    logic                  rd_dphase;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wp, fifo_rp;
    logic [1:0]            fifo_cnt;

    logic aw_hs, ar_hs, w_hs, last_wbeat;
    logic fifo_empty, r_pop, fifo_push, fifo_pop;
    logic rd_all_issued, rd_issue, rd_done;
    logic [2:0] rd_outstanding;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{awaddr, araddr};

    assign aw_hs      = awvalid && awready;
    assign ar_hs      = arvalid && arready;
    assign w_hs       = wvalid && wready;
    assign last_wbeat = (cnt_q == {1'b0, len_q});

    // The SRAM output port acts as a bypass slot in front of the FIFO, so data
    // can leave the cycle it arrives and two outstanding reads sustain 1 beat/cycle.
    assign fifo_empty     = (fifo_cnt == 2'd0);
    assign r_pop          = rvalid && rready;
    assign fifo_push      = rd_dphase && !(fifo_empty && r_pop);
    assign fifo_pop       = r_pop && !fifo_empty;
    assign rd_outstanding = {1'b0, fifo_cnt} + {2'b0, sram_re} + {2'b0, rd_dphase} - {2'b0, r_pop};
    assign rd_all_issued  = (cnt_q == ({1'b0, len_q} + 9'd1));
    assign rd_issue       = (state == RD_BURST) && !rd_all_issued && (rd_outstanding < 3'd2);
    assign rd_done        = (state == RD_BURST) && rd_all_issued && !sram_re && r_pop
                            && (({1'b0, fifo_cnt} + {2'b0, rd_dphase}) == 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs) begin
                    state_nxt = WR_DATA;
                end else if (ar_hs) begin
                    state_nxt = RD_BURST;
                end
            end
            WR_DATA:  if (w_hs && last_wbeat) state_nxt = WR_RESP;
            WR_RESP:  if (bready) state_nxt = IDLE;
            RD_BURST: if (rd_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        case (state)
            IDLE: begin
                awready = !reset && awvalid && (!arvalid || prefer_write);
                arready = !reset && arvalid && (!awvalid || !prefer_write);
            end
            WR_DATA: wready = 1'b1;
            WR_RESP: bvalid = 1'b1;
            RD_BURST: begin
                rvalid = !fifo_empty || rd_dphase;
                rdata  = fifo_empty ? sram_rdata : fifo_mem[fifo_rp];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            prefer_write <= 1'b1;
            sram_addr    <= '0;
            sram_we      <= 1'b0;
            sram_re      <= 1'b0;
            sram_wdata   <= '0;
            wlast_err    <= 1'b0;
            rd_dphase    <= 1'b0;
            fifo_wp      <= 1'b0;
            fifo_rp      <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            wlast_err <= 1'b0;
            rd_dphase <= sram_re;
            if (aw_hs || ar_hs) begin
                addr_q <= aw_hs ? awaddr[ADDR_WIDTH+1:2] : araddr[ADDR_WIDTH+1:2];
                len_q  <= aw_hs ? awlen : arlen;
                cnt_q  <= '0;
                // A contested grant hands priority to the side that lost.
                if (awvalid && arvalid) prefer_write <= ar_hs;
            end
            if (w_hs) begin
                sram_we    <= 1'b1;
                sram_addr  <= addr_q;
                sram_wdata <= wdata;
                addr_q     <= addr_q + 1'b1;
                cnt_q      <= cnt_q + 9'd1;
                wlast_err  <= (wlast != last_wbeat);
            end
            if (rd_issue) begin
                sram_re   <= 1'b1;
                sram_addr <= addr_q;
                addr_q    <= addr_q + 1'b1;
                cnt_q     <= cnt_q + 9'd1;
            end
            if (fifo_push) fifo_wp <= !fifo_wp;
            if (fifo_pop)  fifo_rp <= !fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wp] <= sram_rdata;
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - randomized self-checking bench for axi_sram_responder
module tb_axi_sram_responder;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, sram_we, sram_re, wlast_err;
    logic [DW-1:0] wdata, rdata, sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [AW-1:0] sram_addr;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    bit pref_w = 1'b1;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] sram [0:(1<<AW)-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (sram_we) sram[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= sram[sram_addr];
    end

    axi_sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .wlast_err(wlast_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a, input int i);
        return int'(((a >> 2) + 32'(i)) % (32'd1 << AW));
    endfunction

    task automatic addr_phase(input bit want_w, input bit want_r, output bit got_w, output int hs_cyc);
        bit exp_w;
        awvalid = want_w;
        arvalid = want_r;
        exp_w = want_w && (!want_r || pref_w);
        @(negedge clk);
        chk("awready", awready, exp_w);
        chk("arready", arready, !exp_w && want_r);
        got_w  = exp_w;
        hs_cyc = cyc_n;
        if (want_w && want_r) pref_w = !exp_w;
        tick();
        if (exp_w) awvalid = 1'b0;
        else arvalid = 1'b0;
    endtask

    task automatic chk_wr(input bit hs, input int a, input logic [DW-1:0] d, input bit e);
        chk("sram_we", sram_we, hs);
        if (hs) begin
            chk("sram_waddr", sram_addr, a);
            chk("sram_wdata", sram_wdata, d);
        end
        chk("wlast_err", wlast_err, hs && e);
    endtask

    task automatic write_data(input logic [31:0] a, input int len, input int early,
                              input bit gaps, input bit rnd, input logic [DW-1:0] base);
        int beat = 0;
        bit prev_hs = 1'b0;
        bit prev_err = 1'b0;
        int pa = 0;
        logic [DW-1:0] pd = '0;
        for (int c = 0; c < 2000 && beat <= len; c++) begin
            wdata  = rnd ? DW'($urandom) : base + DW'(beat);
            wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wlast  = (beat == len) || (beat == early);
            @(negedge clk);
            chk_wr(prev_hs, pa, pd, prev_err);
            chk("wready", wready, 1);
            prev_hs = wvalid;
            if (wvalid) begin
                pa = widx(a, beat);
                pd = wdata;
                prev_err = (wlast != (beat == len));
                ref_mem[pa] = wdata;
                beat++;
            end
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk_wr(prev_hs, pa, pd, prev_err);
        chk("wbeats", beat, len + 1);
    endtask

    task automatic write_resp(input int delay);
        bready = 1'b0;
        chk("bvalid", bvalid, 1);
        for (int i = 0; i < delay; i++) begin
            tick();
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
        end
        tick();
        bready = 1'b1;
        @(negedge clk);
        chk("bvalid_hs", bvalid, 1);
        tick();
        bready = 1'b0;
    endtask

    task automatic read_data(input logic [31:0] a, input int len, input int mode,
                             input int hs_cyc, input int abort_beat, output bit aborted);
        int popped = 0;
        int issued = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        bit rr;
        aborted = 1'b0;
        for (int c = 0; c < 3000 && popped <= len; c++) begin
            case (mode)
                0: rr = 1'b1;
                1: rr = (c % 3 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            @(negedge clk);
            if (sram_re) begin
                chk("sram_raddr", sram_addr, widx(a, issued));
                issued++;
            end
            chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (rvalid) begin
                if (popped == abort_beat) begin
                    aborted = 1'b1;
                    return;
                end
                if (first_cyc < 0) first_cyc = cyc_n;
                last_cyc = cyc_n;
                chk("rdata", rdata, ref_mem[widx(a, popped)]);
                if (rready) popped++;
            end
            tick();
        end
        rready = 1'b0;
        chk("rbeats", popped, len + 1);
        chk("rissued", issued, len + 1);
        if (mode == 0) begin
            chk("rlatency", first_cyc - hs_cyc, 3);
            chk("rcontig", last_cyc - first_cyc, len);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int early, input bit gaps,
                            input bit rnd, input logic [DW-1:0] base, input int bdelay);
        bit g;
        int h;
        awaddr = a;
        awlen  = 8'(len);
        addr_phase(1'b1, 1'b0, g, h);
        write_data(a, len, early, gaps, rnd, base);
        write_resp(bdelay);
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input int mode);
        bit g;
        bit ab;
        int h;
        araddr = a;
        arlen  = 8'(len);
        addr_phase(1'b0, 1'b1, g, h);
        read_data(a, len, mode, h, -1, ab);
    endtask

    initial begin
        bit gw;
        bit ab;
        int hc;
        int wl;
        int rl;
        logic [31:0] ra;
        int rlen;
        int early;

        reset = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {awready, arready, wready, bvalid, rvalid}, 0);
        chk("rst_sram", {sram_we, sram_re, wlast_err}, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_rdata", rdata, 0);
        tick();
        reset = 1'b0;

        do_write(32'h100, 0, -1, 1'b0, 1'b0, 32'hDEADBEEF, 2);
        do_read(32'h100, 0, 0);

        do_write(32'h200, 7, -1, 1'b0, 1'b0, 32'h10, 0);
        do_read(32'h200, 7, 0);
        do_read(32'h200, 3, 1);

        wl = 4;
        rl = 4;
        awaddr = 32'h800; awlen = 8'd0;
        araddr = 32'h204; arlen = 8'd1;
        for (int k = 0; k < 8; k++) begin
            addr_phase(wl > 0, rl > 0, gw, hc);
            chk("arb_order", gw, (k % 2) == 0);
            if (gw) begin
                wl--;
                write_data(32'h800, 0, -1, 1'b1, 1'b1, '0);
                write_resp(1);
            end else begin
                rl--;
                read_data(32'h204, 1, 2, hc, -1, ab);
            end
        end
        awvalid = 1'b0;
        arvalid = 1'b0;

        do_write(32'h3FFFC, 1, 0, 1'b0, 1'b1, '0, 0);
        do_read(32'h3FFFC, 1, 2);

        do_write(32'h4000, 255, -1, 1'b0, 1'b1, '0, 0);
        do_read(32'h4000, 255, 0);

        for (int it = 0; it < 6; it++) begin
            ra = $urandom;
            rlen = $urandom_range(0, 20);
            early = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rlen) : -1;
            do_write(ra, rlen, early, 1'b1, 1'b1, '0, $urandom_range(0, 3));
            do_read(ra ^ 32'h3, rlen, 2);
            do_read(ra, rlen, 0);
        end

        araddr = 32'h200;
        arlen  = 8'd7;
        addr_phase(1'b0, 1'b1, gw, hc);
        read_data(32'h200, 7, 0, hc, 2, ab);
        chk("abort_reached", ab, 1);
        arvalid = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_sram_re", sram_re, 0);
        chk("rst_arready", arready, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        arvalid = 1'b0;
        rready = 1'b0;
        pref_w = 1'b1;
        do_read(32'h200, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
